// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 / DMA RAM bus scheduler.
// Holds the scheduler state encoding and bus-owner constants.
package z80_bus_pkg;

   typedef enum logic [2:0] {
      CPU_RUN      = 3'd0,
      CPU_WAIT     = 3'd1,
      STOP_PEND    = 3'd2,
      HANDOVER_IN  = 3'd3,
      DMA_ACTIVE   = 3'd4,
      HANDOVER_OUT = 3'd5,
      FAIR         = 3'd6
   } bus_state_e;

   localparam logic BUS_CPU = 1'b0;
   localparam logic BUS_DMA = 1'b1;

endpackage

// File: rtl/z80_wait_gen.sv
// CPU memory-request edge detector and RAM wait-state generator.
// ram_ready stays low for exactly WAIT_CYCLES clocks per accepted request.
module z80_wait_gen #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic cpu_mreq,
   input  logic en,
   output logic start,
   output logic done,
   output logic ram_ready
);

   logic       mreq_q;
   logic [3:0] wait_cnt;

   assign start = en & cpu_mreq & ~mreq_q;
   assign done  = ~ram_ready & (wait_cnt == 4'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mreq_q    <= 1'b0;
         wait_cnt  <= 4'd0;
         ram_ready <= 1'b1;
      end else begin
         mreq_q <= cpu_mreq;
         if (start) begin
            wait_cnt  <= 4'(WAIT_CYCLES);
            ram_ready <= 1'b0;
         end else if (!ram_ready) begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1)
               ram_ready <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/z80_bus_sched.sv
// Shared RAM bus scheduler between the Z80 and the DMA engine.
// Stops the CPU only at a clock low phase and bounds each DMA grant.
module z80_bus_sched
   import z80_bus_pkg::*;
#(
   parameter int WAIT_CYCLES   = 2,
   parameter int HANDOVER      = 1,
   parameter int DMA_MAX_BURST = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_phase_fall,
   input  logic       cpu_mreq,
   input  logic       dma_req,
   input  logic       dma_beat,
   input  logic       dma_last,
   output logic       cpu_run,
   output logic       ram_ready,
   output logic       dma_grant,
   output logic       bus_owner,
   output logic [7:0] burst_cnt
);

   localparam logic [2:0] HOLD_INIT = 3'(HANDOVER);
   localparam logic [7:0] MAX_BURST = 8'(DMA_MAX_BURST);

   bus_state_e state_q, state_d;
   logic [2:0] hold_q, hold_d;
   logic       ret_fair_q, ret_fair_d;
   logic       cpu_run_d, grant_d, owner_d;
   logic [7:0] burst_d, burst_inc;
   logic       wait_en, mreq_start, wait_done;
   logic       hold_done, dma_end;

   assign wait_en = (state_q == CPU_RUN) || (state_q == FAIR);

   z80_wait_gen #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_wait (
      .clk      (clk),
      .reset    (reset),
      .cpu_mreq (cpu_mreq),
      .en       (wait_en),
      .start    (mreq_start),
      .done     (wait_done),
      .ram_ready(ram_ready)
   );

   // A zero handover still leaves one idle cycle between owners.
   assign hold_done = (hold_q <= 3'd1);
   assign burst_inc = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;
   assign dma_end   = !dma_req ||
                      (dma_beat && (dma_last || burst_inc >= MAX_BURST));

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      ret_fair_d = ret_fair_q;
      cpu_run_d  = cpu_run;
      grant_d    = dma_grant;
      owner_d    = bus_owner;
      burst_d    = burst_cnt;
      unique case (state_q)
         CPU_RUN: begin
            if (mreq_start) begin
               state_d    = CPU_WAIT;
               ret_fair_d = 1'b0;
            end else if (dma_req) begin
               state_d = STOP_PEND;
            end
         end
         CPU_WAIT: begin
            if (wait_done)
               state_d = ret_fair_q ? FAIR : CPU_RUN;
         end
         STOP_PEND: begin
            if (!dma_req) begin
               state_d = CPU_RUN;
            end else if (cpu_phase_fall) begin
               cpu_run_d = 1'b0;
               hold_d    = HOLD_INIT;
               state_d   = HANDOVER_IN;
            end
         end
         HANDOVER_IN: begin
            if (hold_done) begin
               grant_d = 1'b1;
               owner_d = BUS_DMA;
               state_d = DMA_ACTIVE;
            end else begin
               hold_d = hold_q - 3'd1;
            end
         end
         DMA_ACTIVE: begin
            if (dma_beat)
               burst_d = burst_inc;
            if (dma_end) begin
               grant_d = 1'b0;
               hold_d  = HOLD_INIT;
               state_d = HANDOVER_OUT;
            end
         end
         HANDOVER_OUT: begin
            if (hold_done) begin
               cpu_run_d = 1'b1;
               owner_d   = BUS_CPU;
               burst_d   = 8'd0;
               state_d   = FAIR;
            end else begin
               hold_d = hold_q - 3'd1;
            end
         end
         FAIR: begin
            if (mreq_start) begin
               state_d    = CPU_WAIT;
               ret_fair_d = 1'b1;
            end else if (cpu_phase_fall) begin
               state_d = CPU_RUN;
            end
         end
         default: state_d = CPU_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= CPU_RUN;
         hold_q     <= 3'd0;
         ret_fair_q <= 1'b0;
         cpu_run    <= 1'b1;
         dma_grant  <= 1'b0;
         bus_owner  <= BUS_CPU;
         burst_cnt  <= 8'd0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         ret_fair_q <= ret_fair_d;
         cpu_run    <= cpu_run_d;
         dma_grant  <= grant_d;
         bus_owner  <= owner_d;
         burst_cnt  <= burst_d;
      end
   end

endmodule

// File: tb/tb_z80_bus_sched.sv
// Randomized and directed bench for z80_bus_sched against a
// timestamp-based behavioural model of the bus schedule.
module tb_z80_bus_sched;

   localparam int W    = 2;
   localparam int H    = 1;
   localparam int MAXB = 16;
   localparam int GAP  = (H < 1) ? 1 : H;

   logic       clk = 1'b0;
   logic       reset;
   logic       cpu_phase_fall, cpu_mreq, dma_req, dma_beat, dma_last;
   logic       cpu_run, ram_ready, dma_grant, bus_owner;
   logic [7:0] burst_cnt;

   z80_bus_sched #(
      .WAIT_CYCLES  (W),
      .HANDOVER     (H),
      .DMA_MAX_BURST(MAXB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cpu_phase_fall(cpu_phase_fall),
      .cpu_mreq      (cpu_mreq),
      .dma_req       (dma_req),
      .dma_beat      (dma_beat),
      .dma_last      (dma_last),
      .cpu_run       (cpu_run),
      .ram_ready     (ram_ready),
      .dma_grant     (dma_grant),
      .bus_owner     (bus_owner),
      .burst_cnt     (burst_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(string tag, int got, int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Model: who should own the bus, with wait/handover ends as timestamps.
   typedef enum {CPU_FREE, CPU_STALLED, WANT_STOP, GIVING,
                 DMA_OWNS, TAKING_BACK, CPU_OWED} mode_t;

   mode_t md, ret;
   int    k = 0;
   int    free_at, act_at;
   int    m_run, m_ready, m_grant, m_owner, m_beats;
   bit    mreq_prev, last_pf, prev_run;

   task automatic m_reset();
      md = CPU_FREE; ret = CPU_FREE;
      m_run = 1; m_ready = 1; m_grant = 0; m_owner = 0; m_beats = 0;
      mreq_prev = 1'b0; last_pf = 1'b0;
   endtask

   task automatic m_step();
      bit rise;
      k++;
      if (reset) begin
         m_reset();
         return;
      end
      rise      = cpu_mreq && !mreq_prev;
      mreq_prev = cpu_mreq;
      last_pf   = cpu_phase_fall;
      case (md)
         CPU_FREE, CPU_OWED: begin
            if (rise) begin
               ret = md; md = CPU_STALLED;
               free_at = k + W; m_ready = 0;
            end else if (md == CPU_FREE && dma_req) begin
               md = WANT_STOP;
            end else if (md == CPU_OWED && cpu_phase_fall) begin
               md = CPU_FREE;
            end
         end
         CPU_STALLED: if (k == free_at) begin
            m_ready = 1; md = ret;
         end
         WANT_STOP: begin
            if (!dma_req) md = CPU_FREE;
            else if (cpu_phase_fall) begin
               m_run = 0; act_at = k + GAP; md = GIVING;
            end
         end
         GIVING: if (k == act_at) begin
            m_grant = 1; m_owner = 1; md = DMA_OWNS;
         end
         DMA_OWNS: begin
            if (dma_beat) m_beats = (m_beats < 255) ? m_beats + 1 : 255;
            if (!dma_req || (dma_beat && (dma_last || m_beats >= MAXB))) begin
               m_grant = 0; act_at = k + GAP; md = TAKING_BACK;
            end
         end
         TAKING_BACK: if (k == act_at) begin
            m_run = 1; m_owner = 0; m_beats = 0; md = CPU_OWED;
         end
         default: md = CPU_FREE;
      endcase
   endtask

   task automatic check_outs();
      chk("cpu_run", cpu_run, m_run);
      chk("ram_ready", ram_ready, m_ready);
      chk("dma_grant", dma_grant, m_grant);
      chk("bus_owner", bus_owner, m_owner);
      chk("burst_cnt", burst_cnt, m_beats);
      chk("excl", int'(dma_grant && cpu_run), 0);
      chk("rdy_own", int'(bus_owner && !ram_ready), 0);
      if (prev_run && !cpu_run) chk("fall_pf", last_pf, 1);
      prev_run = cpu_run;
   endtask

   task automatic tick();
      @(posedge clk);
      m_step();
      #1;
      check_outs();
   endtask

   task automatic clr();
      cpu_phase_fall = 0; cpu_mreq = 0; dma_req = 0;
      dma_beat = 0; dma_last = 0;
   endtask

   task automatic settle();
      clr();
      repeat (4) begin
         cpu_phase_fall = 1; tick();
         cpu_phase_fall = 0; tick();
      end
   endtask

   int lows, peak, min_run;

   initial begin
      clr();
      reset = 1;
      prev_run = 1;
      m_reset();
      repeat (3) tick();
      reset = 0;
      chk("rst_run", cpu_run, 1);
      chk("rst_rdy", ram_ready, 1);
      chk("rst_grant", dma_grant, 0);
      chk("rst_burst", burst_cnt, 0);

      // wait states; mreq held high must not retrigger
      tick();
      lows = 0;
      cpu_mreq = 1;
      repeat (8) begin
         tick();
         if (!ram_ready) lows++;
      end
      chk("wait_len", lows, W);
      cpu_mreq = 0;
      tick();

      // normal DMA transfer of 4 beats
      dma_req = 1;
      repeat (5) tick();
      cpu_phase_fall = 1; tick();
      cpu_phase_fall = 0;
      chk("stop_run", cpu_run, 0);
      tick();
      chk("grant_on", dma_grant, 1);
      dma_beat = 1;
      for (int i = 0; i < 4; i++) begin
         dma_last = (i == 3);
         tick();
      end
      clr();
      chk("grant_off", dma_grant, 0);
      tick();
      chk("run_back", cpu_run, 1);
      chk("burst_clr", burst_cnt, 0);
      settle();

      // burst limit with continuous beats
      peak = 0;
      dma_req = 1; dma_beat = 1;
      for (int i = 0; i < 80; i++) begin
         cpu_phase_fall = (i % 4 == 3);
         tick();
         if (burst_cnt > peak) peak = burst_cnt;
      end
      chk("burst_peak", peak, MAXB);
      settle();

      // mreq edge and dma_req together
      cpu_mreq = 1; dma_req = 1;
      tick();
      chk("simul_wait", ram_ready, 0);
      cpu_phase_fall = 1; tick();
      cpu_phase_fall = 0;
      chk("simul_run", cpu_run, 1);
      repeat (6) begin
         cpu_phase_fall = 1; tick();
         cpu_phase_fall = 0; tick();
      end
      settle();

      // withdrawn request before the strobe
      min_run = 1;
      dma_req = 1; tick(); tick();
      dma_req = 0; cpu_phase_fall = 1; tick();
      cpu_phase_fall = 0;
      repeat (4) begin
         tick();
         if (!cpu_run) min_run = 0;
      end
      chk("no_stop", min_run, 1);
      settle();

      // async reset in the middle of a grant
      dma_req = 1; tick();
      cpu_phase_fall = 1; tick();
      cpu_phase_fall = 0; tick();
      dma_beat = 1;
      repeat (7) tick();
      dma_beat = 0;
      chk("pre_rst_burst", burst_cnt, 7);
      #3 reset = 1;
      #1;
      chk("arst_run", cpu_run, 1);
      chk("arst_rdy", ram_ready, 1);
      chk("arst_grant", dma_grant, 0);
      chk("arst_owner", bus_owner, 0);
      chk("arst_burst", burst_cnt, 0);
      m_reset();
      prev_run = 1;
      clr();
      tick(); tick();
      reset = 0;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) dma_req = ~dma_req;
         if ($urandom_range(0, 5) == 0) cpu_mreq = ~cpu_mreq;
         cpu_phase_fall = ($urandom_range(0, 4) == 0);
         dma_beat       = $urandom_range(0, 1) != 0;
         dma_last       = ($urandom_range(0, 9) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
